if_inst_queue: RTL and testbench
================================

Name: if_inst_queue

Overview:
Decoupling instruction queue between the fetch unit and the IF/ID pipeline register.
- Accepts fetched, already-realigned and expanded instructions with their PC, compressed flag, trap bits and branch-prediction tag via valid/ready.
- Presents them in order to decode, which can stall without stalling fetch.
- Supports pipeline flush and a trap fence that stops fetch after a faulting instruction.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
TRAP_W, 16, width of per-instruction trap vector (matches shared TRAP bus width)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous discard of all entries (branch mispredict / trap redirect)
enq_valid_i  in  1  fetch presents an instruction
enq_ready_o  out  1  queue accepts this cycle
enq_pc_i  in  32  instruction PC
enq_inst_i  in  32  instruction word (expanded if compressed)
enq_compressed_i  in  1  original instruction was 16-bit
enq_trap_i  in  TRAP_W  fetch-side trap bits (misaligned / access / page fault)
enq_pdt_i  in  1  predictor said taken
enq_pdt_tag_i  in  32  predicted target PC
deq_valid_o  out  1  head entry valid
deq_ready_i  in  1  decode consumes head
deq_pc_o  out  32  head PC
deq_inst_o  out  32  head instruction
deq_compressed_o  out  1  head compressed flag
deq_trap_o  out  TRAP_W  head trap bits
deq_pdt_o  out  1  head prediction
deq_pdt_tag_o  out  32  head predicted target
deq_snpc_o  out  32  head PC + 2 if compressed, else + 4
count_o  out  clog2(DEPTH)+1  current occupancy

Behaviour:
Storage and handshake
- Circular buffer with rd_ptr/wr_ptr of clog2(DEPTH) bits; both wrap naturally modulo DEPTH.
- count register of clog2(DEPTH)+1 bits.
- Enqueue fires when enq_valid_i & enq_ready_o; dequeue fires when deq_valid_o & deq_ready_i.
- enq_ready_o = (count != DEPTH) & !fence & !flush_i. No full-queue pass-through: when full, enq_ready_o is 0 even if a dequeue occurs the same cycle.
- deq_valid_o = (count != 0). Head fields are driven from rd_ptr storage (first-word fall-through).
- Latency: an enqueued entry is visible at deq one cycle later. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count unchanged, both pointers advance.

Empty outputs
- When empty: deq_inst_o = 32'h00000013 (NOP). deq_pc_o, deq_trap_o, deq_pdt_o, deq_pdt_tag_o, deq_compressed_o = 0.
- deq_snpc_o = deq_pc_o + (deq_compressed_o ? 2 : 4), 32-bit wrapping add.

Trap fence
- If an enqueue fires with |enq_trap_i, fence is set the next cycle.
- Fence forces enq_ready_o = 0 until flush_i or rst.
- The faulting entry itself is stored and delivered normally.

Flush
- flush_i has priority over everything.
- Next cycle: count = 0, pointers = 0, fence = 0.
- Any enqueue or dequeue presented in the flush cycle is discarded: not stored, not counted.
- deq_valid_o = 0 in the cycle after flush.

Reset
- Asynchronous: pointers, count and fence cleared; all outputs take their empty values.
- Storage contents need no reset.
- Reset mid-operation loses all entries; no partial state survives.

Decomposition:
- Shared package / sysconfig macros: TRAP_W, the NOP encoding 32'h00000013, XLEN=32.
- Define an entry struct/concatenation {pc, inst, compressed, trap, pdt, pdt_tag} of 98+TRAP_W bits in the package.
- One natural sub-module: sync_fifo_core (generic pointer/count/storage, width and depth parameterised). The top adds the fence, the empty-NOP muxing and the snpc adder.

Test Plan:
- Reset, then enqueue 4 entries PC 0x80000000/4/8/C with deq_ready_i=0 -> count_o=4, enq_ready_o=0; dequeue 4 -> PCs in order, deq_inst_o=0x00000013 after drain.
- Enqueue compressed PC 0x80000002 -> deq_snpc_o=0x80000004; non-compressed PC 0xFFFFFFFC -> deq_snpc_o=0x00000000.
- Continuous enq/deq each cycle at count=1 for 20 cycles -> count stays 1, pointers wrap, order preserved, 1-cycle latency.
- With 2 entries, assert flush_i while enqueuing PC 0x100 -> next cycle deq_valid_o=0, count_o=0, PC 0x100 never appears.
- Enqueue entry with trap bit 12 set at PC 0x200 -> enq_ready_o=0 from next cycle; entry dequeues with deq_trap_o[12]=1; flush_i -> enq_ready_o=1.
- Assert rst asynchronously mid-burst with 3 entries -> deq_valid_o=0, count_o=0 immediately, no entries after release.

Source files
------------

// File: rtl/if_inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
//   XLEN        : architectural register / PC width
//   TRAP_W      : width of the shared per-instruction trap vector
//   NOP_INST    : canonical NOP (addi x0, x0, 0) shown on an empty queue
//   iq_entry_t  : one queued instruction, in the same field order that the
//                 top packs into the FIFO word
package if_inst_queue_pkg;

  localparam int XLEN   = 32;
  localparam int TRAP_W = 16;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic              compressed;
    logic [TRAP_W-1:0] trap;
    logic              pdt;
    logic [XLEN-1:0]   pdt_tag;
  } iq_entry_t;

  // Entry width for an arbitrary trap width: pc + inst + compressed + pdt + pdt_tag = 98.
  function automatic int entry_w(input int trap_w);
    return 98 + trap_w;
  endfunction

endpackage

// File: rtl/if_inst_queue_fifo_core.sv
// Generic first-word-fall-through circular FIFO.
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   clr_i     : synchronous clear, dominates push/pop
//   push_i    : write wdata_i at the tail (caller guarantees not full)
//   pop_i     : advance the head (caller guarantees not empty)
//   wdata_i   : write data
//   rdata_o   : head data (undefined when empty)
//   count_o   : occupancy, 0..DEPTH
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
module if_inst_queue_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers are exactly AW bits wide so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_inst_queue.sv
// Decoupling instruction queue between fetch and the IF/ID register.
//   clk, rst              : clock, asynchronous active-high reset
//   flush_i               : discard everything; dominates all other inputs
//   enq_*                 : fetched instruction (pc, inst, compressed, trap,
//                           pdt, pdt_tag) with enq_valid_i / enq_ready_o
//   deq_*                 : head instruction with deq_valid_o / deq_ready_i,
//                           plus deq_snpc_o (sequential next PC)
//   count_o               : current occupancy
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. valid must not depend on ready; ready here depends on
// occupancy, the trap fence and flush_i, never on enq_valid_i.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TRAP_W = if_inst_queue_pkg::TRAP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  logic [XLEN-1:0]        enq_pc_i,
  input  logic [31:0]            enq_inst_i,
  input  logic                   enq_compressed_i,
  input  logic [TRAP_W-1:0]      enq_trap_i,
  input  logic                   enq_pdt_i,
  input  logic [XLEN-1:0]        enq_pdt_tag_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output logic [XLEN-1:0]        deq_pc_o,
  output logic [31:0]            deq_inst_o,
  output logic                   deq_compressed_o,
  output logic [TRAP_W-1:0]      deq_trap_o,
  output logic                   deq_pdt_o,
  output logic [XLEN-1:0]        deq_pdt_tag_o,
  output logic [XLEN-1:0]        deq_snpc_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int EW = entry_w(TRAP_W);

  logic          fence_q, fence_d;
  logic          full, empty;
  logic          enq_fire, deq_fire;
  logic [EW-1:0] wdata, rdata;

  // Head entry fields, unpacked in the same order they were packed.
  logic [XLEN-1:0]   h_pc, h_pdt_tag;
  logic [31:0]       h_inst;
  logic              h_comp, h_pdt;
  logic [TRAP_W-1:0] h_trap;

  // No pass-through when full: ready ignores a same-cycle dequeue.
  assign enq_ready_o = !full && !fence_q && !flush_i;
  assign deq_valid_o = !empty;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;

  assign wdata = {enq_pc_i, enq_inst_i, enq_compressed_i, enq_trap_i,
                  enq_pdt_i, enq_pdt_tag_i};

  if_inst_queue_fifo_core #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .push_i  (enq_fire),
    .pop_i   (deq_fire),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Once a trapping instruction is accepted nothing behind it may enter
  // until the redirect (flush) arrives; the trapping entry itself drains.
  always_comb begin
    fence_d = fence_q;
    if (flush_i)                        fence_d = 1'b0;
    else if (enq_fire && |enq_trap_i)   fence_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fence_q <= 1'b0;
    else     fence_q <= fence_d;
  end

  assign {h_pc, h_inst, h_comp, h_trap, h_pdt, h_pdt_tag} = rdata;

  // Empty queue presents a clean NOP so stale storage never leaks to decode.
  assign deq_pc_o         = empty ? '0       : h_pc;
  assign deq_inst_o       = empty ? NOP_INST : h_inst;
  assign deq_compressed_o = empty ? 1'b0     : h_comp;
  assign deq_trap_o       = empty ? '0       : h_trap;
  assign deq_pdt_o        = empty ? 1'b0     : h_pdt;
  assign deq_pdt_tag_o    = empty ? '0       : h_pdt_tag;

  assign deq_snpc_o = deq_pc_o + (deq_compressed_o ? 32'd2 : 32'd4);

endmodule

// File: tb/tb_if_inst_queue.sv
module tb_if_inst_queue;

  localparam int DEPTH  = 4;
  localparam int TRAP_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [31:0]       enq_pc_i;
  logic [31:0]       enq_inst_i;
  logic              enq_compressed_i;
  logic [TRAP_W-1:0] enq_trap_i;
  logic              enq_pdt_i;
  logic [31:0]       enq_pdt_tag_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [31:0]       deq_pc_o;
  logic [31:0]       deq_inst_o;
  logic              deq_compressed_o;
  logic [TRAP_W-1:0] deq_trap_o;
  logic              deq_pdt_o;
  logic [31:0]       deq_pdt_tag_o;
  logic [31:0]       deq_snpc_o;
  logic [2:0]        count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  if_inst_queue #(.DEPTH(DEPTH), .TRAP_W(TRAP_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .enq_valid_i      (enq_valid_i),
    .enq_ready_o      (enq_ready_o),
    .enq_pc_i         (enq_pc_i),
    .enq_inst_i       (enq_inst_i),
    .enq_compressed_i (enq_compressed_i),
    .enq_trap_i       (enq_trap_i),
    .enq_pdt_i        (enq_pdt_i),
    .enq_pdt_tag_i    (enq_pdt_tag_i),
    .deq_valid_o      (deq_valid_o),
    .deq_ready_i      (deq_ready_i),
    .deq_pc_o         (deq_pc_o),
    .deq_inst_o       (deq_inst_o),
    .deq_compressed_o (deq_compressed_o),
    .deq_trap_o       (deq_trap_o),
    .deq_pdt_o        (deq_pdt_o),
    .deq_pdt_tag_o    (deq_pdt_tag_o),
    .deq_snpc_o       (deq_snpc_o),
    .count_o          (count_o)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then move just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction word derived from the PC so every entry is distinct.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0093;
  endfunction

  task automatic drive_enq(input logic v, input logic [31:0] pc, input logic comp,
                           input logic [TRAP_W-1:0] trap);
    enq_valid_i      = v;
    enq_pc_i         = pc;
    enq_inst_i       = inst_of(pc);
    enq_compressed_i = comp;
    enq_trap_i       = trap;
    enq_pdt_i        = pc[2];
    enq_pdt_tag_i    = pc + 32'h40;
  endtask

  task automatic idle();
    drive_enq(1'b0, 32'h0, 1'b0, '0);
    deq_ready_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    // reset values
    chk("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_deq_inst", deq_inst_o, 32'h0000_0013);
    chk("rst_deq_pc", deq_pc_o, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, '0);
      #1;
      chk("fill_ready", 32'(enq_ready_o), 32'd1);
      tick();
    end
    idle();
    #1;
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(enq_ready_o), 32'd0);
    chk("full_head_pc", deq_pc_o, 32'h8000_0000);
    chk("full_head_inst", deq_inst_o, inst_of(32'h8000_0000));
    chk("full_head_pdt_tag", deq_pdt_tag_o, 32'h8000_0040);

    // full + dequeue same cycle: no pass-through
    drive_enq(1'b1, 32'hDEAD_0000, 1'b0, '0);
    deq_ready_i = 1'b1;
    #1;
    chk("full_no_passthru", 32'(enq_ready_o), 32'd0);
    tick();
    drive_enq(1'b0, 32'h0, 1'b0, '0);
    #1;
    chk("after_pop_count", 32'(count_o), 32'd3);

    // drain in order
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", deq_pc_o, 32'h8000_0000 + 32'(4 * i));
      chk("drain_pdt", 32'(deq_pdt_o), 32'(i % 2));
      tick();
    end
    deq_ready_i = 1'b0;
    #1;
    chk("drained_valid", 32'(deq_valid_o), 32'd0);
    chk("drained_inst_nop", deq_inst_o, 32'h0000_0013);
    chk("drained_snpc", deq_snpc_o, 32'd4);
    chk("drained_count", 32'(count_o), 32'd0);

    // snpc: compressed, then PC wrap; 1-cycle latency
    drive_enq(1'b1, 32'h8000_0002, 1'b1, '0);
    #1;
    chk("no_bypass_valid", 32'(deq_valid_o), 32'd0);
    tick();
    drive_enq(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    deq_ready_i = 1'b1;
    #1;
    chk("snpc_comp", deq_snpc_o, 32'h8000_0004);
    chk("comp_flag", 32'(deq_compressed_o), 32'd1);
    tick();
    drive_enq(1'b0, 32'h0, 1'b0, '0);
    deq_ready_i = 1'b0;
    #1;
    chk("snpc_wrap", deq_snpc_o, 32'h0000_0000);
    chk("wrap_count", 32'(count_o), 32'd1);

    // streaming at count=1 for 20 cycles
    exp_q.push_back(32'hFFFF_FFFC);
    for (int k = 0; k < 20; k++) begin
      drive_enq(1'b1, 32'h0000_1000 + 32'(4 * k), 1'b0, '0);
      deq_ready_i = 1'b1;
      #1;
      chk("stream_count", 32'(count_o), 32'd1);
      chk("stream_pc", deq_pc_o, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h0000_1000 + 32'(4 * k));
    end
    drive_enq(1'b0, 32'h0, 1'b0, '0);
    #1;
    chk("stream_last_pc", deq_pc_o, exp_q[0]);
    chk("stream_last_inst", deq_inst_o, inst_of(32'h0000_104C));
    void'(exp_q.pop_front());
    tick();
    deq_ready_i = 1'b0;
    #1;
    chk("stream_end_count", 32'(count_o), 32'd0);

    // flush with 2 entries while enqueuing 0x100
    drive_enq(1'b1, 32'h10, 1'b0, '0);
    tick();
    drive_enq(1'b1, 32'h14, 1'b0, '0);
    tick();
    drive_enq(1'b1, 32'h100, 1'b0, '0);
    deq_ready_i = 1'b1;
    flush_i     = 1'b1;
    #1;
    chk("flush_ready", 32'(enq_ready_o), 32'd0);
    tick();
    idle();
    #1;
    chk("post_flush_valid", 32'(deq_valid_o), 32'd0);
    chk("post_flush_count", 32'(count_o), 32'd0);
    tick();
    #1;
    chk("post_flush_count2", 32'(count_o), 32'd0);
    drive_enq(1'b1, 32'h20, 1'b0, '0);
    tick();
    idle();
    #1;
    chk("post_flush_head", deq_pc_o, 32'h20);
    chk("post_flush_cnt1", 32'(count_o), 32'd1);
    deq_ready_i = 1'b1;
    tick();
    deq_ready_i = 1'b0;

    // trap fence
    drive_enq(1'b1, 32'h200, 1'b0, 16'h1000);
    #1;
    chk("trap_ready_pre", 32'(enq_ready_o), 32'd1);
    tick();
    drive_enq(1'b1, 32'h204, 1'b0, '0);
    #1;
    chk("fence_ready", 32'(enq_ready_o), 32'd0);
    chk("trap_head_pc", deq_pc_o, 32'h200);
    chk("trap_bit12", 32'(deq_trap_o[12]), 32'd1);
    tick();
    #1;
    chk("fence_count", 32'(count_o), 32'd1);
    deq_ready_i = 1'b1;
    tick();
    deq_ready_i = 1'b0;
    #1;
    chk("fence_drain_count", 32'(count_o), 32'd0);
    chk("fence_hold_ready", 32'(enq_ready_o), 32'd0);
    drive_enq(1'b0, 32'h0, 1'b0, '0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("fence_clear_ready", 32'(enq_ready_o), 32'd1);

    // async reset mid-burst with 3 entries
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'h300 + 32'(4 * i), 1'b0, '0);
      tick();
    end
    #1;
    chk("pre_rst_count", 32'(count_o), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(deq_valid_o), 32'd0);
    chk("async_rst_count", 32'(count_o), 32'd0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_valid", 32'(deq_valid_o), 32'd0);
    chk("post_rst_count", 32'(count_o), 32'd0);
    drive_enq(1'b1, 32'h400, 1'b0, '0);
    tick();
    idle();
    #1;
    chk("post_rst_head", deq_pc_o, 32'h400);
    chk("post_rst_cnt1", 32'(count_o), 32'd1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
